// File: rtl/poly_reduce_seq_pkg.sv
// Shared Kyber constants, coefficient type and sequencer state encoding.
package poly_reduce_seq_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int COEFF_W   = 16;

    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/poly_reduce_seq_if.sv
// Control handshake plus coefficient RAM read/write bus of the sequencer.
interface poly_reduce_seq_if #(
    parameter int AW = 8
);
    logic                         start;
    logic                         hold;
    logic                         busy;
    logic                         done;
    logic                         rd_en;
    logic [AW-1:0]                rd_addr;
    poly_reduce_seq_pkg::coeff_t  rd_data;
    logic                         wr_en;
    logic [AW-1:0]                wr_addr;
    poly_reduce_seq_pkg::coeff_t  wr_data;

    // Sequencer side.
    modport master (
        input  start, hold, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    // Controller / RAM side.
    modport slave (
        output start, hold, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/barrett_reduce.sv
// Two-stage Barrett reducer: t = a - q*round(a*v / 2^26), centred mod q.
// set acts as a clock enable for both stages.
module barrett_reduce
    import poly_reduce_seq_pkg::*;
(
    input  logic   clk,
    input  logic   set,
    input  coeff_t a,
    output coeff_t t
);
    localparam logic [31:0] BARRETT_V = 32'd20159;
    localparam logic [31:0] ROUND_C   = 32'd33554432;

    coeff_t             a_q;
    logic signed [31:0] prod_q;
    logic signed [31:0] a_ext;
    logic signed [31:0] diff;

    // Low 32 bits of the two's-complement product are sign-agnostic.
    assign a_ext = {{16{a_q[15]}}, a_q};
    assign diff  = a_ext - (prod_q >>> 26) * 32'(KYBER_Q);

    // Stage 1 registers the scaled product, stage 2 the corrected remainder.
    always_ff @(posedge clk) begin
        if (set) begin
            a_q    <= a;
            prod_q <= {{16{a[15]}}, a} * BARRETT_V + ROUND_C;
            t      <= diff[15:0];
        end
    end
endmodule

// File: rtl/poly_reduce_seq_lat_pipe.sv
// Valid + address shift register that mirrors the read-to-write latency.
module poly_reduce_seq_lat_pipe #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic          upstream_vld
);
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    addr [DEPTH];

    // Shift one stage per unfrozen cycle; freeze holds every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else if (!freeze) begin
            vld     <= {vld[DEPTH-2:0], in_vld};
            addr[0] <= in_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                addr[i] <= addr[i-1];
            end
        end
    end

    assign out_vld      = vld[DEPTH-1];
    assign out_addr     = addr[DEPTH-1];
    // Anything still in flight behind the tail stage.
    assign upstream_vld = |vld[DEPTH-2:0];
endmodule

// File: rtl/poly_reduce_seq.sv
// Sweeps one polynomial through barrett_reduce and writes results in place.
module poly_reduce_seq
    import poly_reduce_seq_pkg::*;
#(
    parameter int N       = KYBER_N,
    parameter int AW      = 8,
    parameter int RED_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    poly_reduce_seq_if.master  bus
);
    localparam int unsigned DEPTH = 32'(1 + RED_LAT);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    seq_state_t    state;
    logic [AW-1:0] rd_cnt;
    logic          busy_q;
    logic          done_q;
    logic          rd_fire;
    logic          freeze;
    logic          red_set;
    logic          tail_vld;
    logic [AW-1:0] tail_addr;
    logic          upstream_vld;
    coeff_t        red_t;

    assign rd_fire = (state == ST_RUN) && !bus.hold;
    assign freeze  = busy_q && bus.hold;
    assign red_set = busy_q && !bus.hold;

    // Sweep control: start, address issue, drain and one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        rd_cnt <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!bus.hold) begin
                        rd_cnt <= rd_cnt + AW'(1);
                        if (rd_cnt == LAST_ADDR) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the tail remains; its write happens this cycle.
                    if (!bus.hold && !upstream_vld) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    poly_reduce_seq_lat_pipe #(
        .DEPTH (DEPTH),
        .AW    (32'(AW))
    ) u_lat_pipe (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .in_vld       (rd_fire),
        .in_addr      (rd_cnt),
        .out_vld      (tail_vld),
        .out_addr     (tail_addr),
        .upstream_vld (upstream_vld)
    );

    barrett_reduce u_barrett (
        .clk (clk),
        .set (red_set),
        .a   (bus.rd_data),
        .t   (red_t)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_fire;
    assign bus.rd_addr = rd_cnt;
    assign bus.wr_en   = tail_vld && !bus.hold;
    assign bus.wr_addr = tail_addr;
    assign bus.wr_data = tail_vld ? red_t : '0;
endmodule

// File: tb/tb_poly_reduce_seq.sv
// Scoreboard bench for poly_reduce_seq with a behavioural RAM model.
module tb_poly_reduce_seq;
    import poly_reduce_seq_pkg::*;

    typedef struct {
        logic [7:0] addr;
        coeff_t     val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passed;
    int   wr_count;
    int   ucnt;
    int   rd_u [256];
    coeff_t ram [256];
    exp_t exp_q [$];

    poly_reduce_seq_if #(.AW(8)) bus ();

    poly_reduce_seq #(
        .N       (256),
        .AW      (8),
        .RED_LAT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient RAM: one-cycle read latency, holds rd_data when idle.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
        if (bus.wr_en) ram[bus.wr_addr] = bus.wr_data;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Centred representative of a modulo q.
    function automatic coeff_t cmod(input coeff_t a);
        int r;
        r = int'(a) % KYBER_Q;
        if (r < 0) r += KYBER_Q;
        if (r > (KYBER_Q - 1) / 2) r -= KYBER_Q;
        return coeff_t'(r);
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int i = 0; i < 256; i++) begin
            e.addr = 8'(i);
            e.val  = cmod(ram[i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: write-back ordering, data, latency and hold behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.rd_en) rd_u[bus.rd_addr] = ucnt;
            if (bus.hold && bus.busy) chk("no_wr_during_hold", longint'(bus.wr_en), 0);
            if (bus.wr_en) begin
                wr_count++;
                chk("wr_expected", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", longint'(bus.wr_addr), longint'(e.addr));
                    chk("wr_data", longint'(bus.wr_data), longint'(e.val));
                    chk("wr_latency", longint'(ucnt - rd_u[bus.wr_addr]), 3);
                    chk("wr_range", longint'(bus.wr_data >= -1664 && bus.wr_data <= 1664), 1);
                end
            end
            if (!bus.hold) ucnt++;
        end
    end

    task automatic preload_basic();
        for (int i = 0; i < 256; i++) ram[i] = '0;
        ram[0] = -16'sd26227;
        ram[1] = 16'sd30000;
    endtask

    task automatic do_sweep(input string tag, input int hold_addr, input int hold_len,
                            input int drain_len, input bit noisy);
        int t0, left, base, dlat;
        bit seen, did_rd, did_dr;
        push_expect();
        base = wr_count;
        bus.start = 1'b1;
        t0 = cyc;
        cycle();
        bus.start = 1'b0;
        chk({tag, "_busy_after_start"}, longint'(bus.busy), 1);
        seen = 0; left = 0; did_rd = 0; did_dr = 0; dlat = -1;
        for (int n = 1; n < 1000 && !seen; n++) begin
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            if (bus.done) begin
                seen = 1;
                dlat = cyc - t0;
                bus.start = noisy;
            end else begin
                if (noisy && n == 50) bus.start = 1'b1;
                if (left > 0) begin
                    bus.hold = 1'b1;
                    left--;
                end else if (!did_rd && hold_len > 0 && bus.busy && int'(bus.rd_addr) == hold_addr) begin
                    bus.hold = 1'b1;
                    left = hold_len - 1;
                    did_rd = 1;
                end else if (!did_dr && drain_len > 0 && wr_count - base >= 254) begin
                    bus.hold = 1'b1;
                    left = drain_len - 1;
                    did_dr = 1;
                end
            end
            cycle();
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk({tag, "_done_latency"}, longint'(dlat), longint'(260 + hold_len + drain_len));
        chk({tag, "_done_one_cycle"}, longint'(bus.done), 0);
        chk({tag, "_busy_after_done"}, longint'(bus.busy), 0);
        repeat (4) cycle();
        chk({tag, "_idle_after_done"}, longint'(bus.busy), 0);
        chk({tag, "_write_count"}, longint'(wr_count - base), 256);
        chk({tag, "_queue_empty"}, longint'(exp_q.size()), 0);
    endtask

    initial begin
        int base;
        checks = 0; passed = 0; wr_count = 0; ucnt = 0; cyc = 0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        rst = 1'b1;
        preload_basic();
        cycle();
        cycle();
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_rd_en", longint'(bus.rd_en), 0);
        chk("rst_wr_en", longint'(bus.wr_en), 0);
        chk("rst_rd_addr", longint'(bus.rd_addr), 0);
        chk("rst_wr_addr", longint'(bus.wr_addr), 0);
        chk("rst_wr_data", longint'(bus.wr_data), 0);
        rst = 1'b0;
        repeat (2) cycle();

        do_sweep("basic", 0, 0, 0, 1'b0);
        chk("basic_ram0", longint'(ram[0]), 405);
        chk("basic_ram1", longint'(ram[1]), 39);
        chk("basic_ram2", longint'(ram[2]), 0);

        preload_basic();
        do_sweep("stall", 100, 3, 2, 1'b0);
        chk("stall_ram0", longint'(ram[0]), 405);
        chk("stall_ram1", longint'(ram[1]), 39);

        preload_basic();
        do_sweep("noisy_start", 0, 0, 0, 1'b1);

        // Abort a sweep with reset at read address 50.
        preload_basic();
        push_expect();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int n = 0; n < 400 && !(bus.rd_en && bus.rd_addr == 8'd50); n++) cycle();
        chk("rst_reach_addr50", longint'(bus.rd_en && bus.rd_addr == 8'd50), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", longint'(bus.busy), 0);
        chk("abort_rd_en", longint'(bus.rd_en), 0);
        chk("abort_wr_en", longint'(bus.wr_en), 0);
        chk("abort_rd_addr", longint'(bus.rd_addr), 0);
        chk("abort_wr_data", longint'(bus.wr_data), 0);
        exp_q.delete();
        repeat (2) cycle();
        rst = 1'b0;
        base = wr_count;
        repeat (10) cycle();
        chk("abort_no_writes", longint'(wr_count - base), 0);
        chk("abort_idle", longint'(bus.busy), 0);
        do_sweep("post_rst", 0, 0, 0, 1'b0);
        chk("post_rst_ram0", longint'(ram[0]), 405);

        void'($urandom(32'hC0FFEE));
        for (int i = 0; i < 256; i++) ram[i] = coeff_t'($urandom_range(65535, 0));
        do_sweep("random", 0, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/poly_reduce_seq.md
Name: poly_reduce_seq

Overview:
- Sequencer that sweeps one Kyber polynomial (N coefficients, signed 16-bit) through a barrett_reduce instance and writes the results back in place.
- Sits between the polynomial coefficient RAM and the barrett reducer. Invoked after NTT or basemul passes to bring coefficients back to the centred range modulo q = 3329.
- Handles start/done handshake, address generation, read-to-write latency alignment, stall (hold) and drain.

Parameters:
- N, 256, coefficients per polynomial.
- AW, 8, address width; N <= 2**AW.
- RED_LAT, 2, barrett_reduce latency in cycles from a sampled to t valid while set=1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- hold  in  1  stall; freezes the entire sweep while high.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last write-back.
- rd_en  out  1  coefficient RAM read strobe.
- rd_addr  out  AW  read address.
- rd_data  in  16  signed read data, valid 1 cycle after rd_en; RAM holds rd_data when rd_en=0.
- wr_en  out  1  write-back strobe.
- wr_addr  out  AW  write-back address.
- wr_data  out  16  signed reduced coefficient.

Behaviour:
- Reset (async, immediate): state=IDLE, read counter=0, valid/address pipe cleared. busy, done, rd_en and wr_en are 0; rd_addr, wr_addr and wr_data are 0. Reset mid-sweep aborts the sweep; no further wr_en until the next start.
- States IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, read counter=0. start while busy or in DONE is ignored, not queued.
- RUN: each cycle with hold=0, rd_en=1 and rd_addr=counter; the counter increments. On the cycle that issues address N-1 -> DRAIN. With hold=1, rd_en=0 and the counter is frozen.
- Pipeline:
  - A valid/address shift register of depth 1+RED_LAT tracks each read.
  - rd_data feeds barrett_reduce.a, with barrett_reduce.set = ~hold in RUN/DRAIN and 0 otherwise.
  - The tail of the pipe drives wr_en, wr_addr and wr_data = barrett_reduce.t.
- Latency: wr for address k occurs exactly 1+RED_LAT unstalled cycles after rd for address k. Write order equals read order. Exactly N writes per sweep, each address written once.
- hold freezes the shift register, the counter and the reducer together. wr_en=0 while hold=1; the pending write completes on the first cycle after hold falls. hold in IDLE/DONE has no effect.
- DRAIN: no reads. When the pipe is empty after the final write -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. A start on the same cycle as done is ignored.
- In-place hazard: write address k never precedes read address k, so no forwarding is required.
- Arithmetic: outputs are barrett_reduce results, signed 16-bit, congruent to the input mod 3329, in [-1664, 1664]. No extra width growth or saturation.
- Sweep length: N + 1 + RED_LAT + 1 cycles from start to done with hold=0.

Decomposition:
- Shared kyber package: KYBER_Q=3329, KYBER_N=256, coefficient width 16, state encoding constants for the sequencer.
- Instantiates the existing barrett_reduce (ports clk, set, a, t) unchanged.
- One natural sub-module, lat_pipe: a parameterised valid+address shift register with a freeze enable, depth 1+RED_LAT.

Test Plan:
- Single sweep, RAM preloaded with addr0=-26227, addr1=30000, remaining entries 0, start pulse -> RAM[0]=405, RAM[1]=39, others 0; done one cycle at start+N+RED_LAT+2; exactly 256 wr_en pulses.
- Latency/ordering -> every wr_addr sequence is 0..255 ascending; each write lands exactly RED_LAT+1 cycles after its read.
- hold asserted 3 cycles at read 100 and 2 cycles during DRAIN -> no write while hold=1, no lost or duplicated addresses, done delayed by exactly 5 cycles, results identical to the unstalled run.
- start pulses during RUN and on the done cycle -> ignored; only one sweep (256 writes) occurs.
- rst asserted at read address 50 -> outputs 0 immediately, wr_en stays 0, state IDLE; a new start then completes a full correct sweep.
- Random RAM contents (seeded, full int16 range) -> each result equals the input mod 3329 and lies in [-1664, 1664]; scoreboard checks all 256 entries.
